// File: rtl/pwm_snd_decoder.sv
// Duty-cycle decoder: averages a 1-bit PWM stream over 2^WIN_LOG2-clock windows and emits one PCM sample per window; PWM_DEC_CIC2_EN adds a second boxcar stage.
// Sample appears the cycle after window end (2-cycle synchroniser in front); held until accepted, newer results dropped with sticky overrun.
module pwm_snd_decoder #(
    parameter int WIN_LOG2 = 7,
    parameter int OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                snd_in,
    output logic [OUT_BITS-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                overrun
);

    localparam logic [WIN_LOG2-1:0] WCNT_MAX = '1;

    logic                s1;
    logic                s2;
    logic [WIN_LOG2-1:0] wcnt;
    logic [WIN_LOG2:0]   acc;
    logic [WIN_LOG2:0]   total;
    logic [WIN_LOG2-1:0] sat;
    logic [WIN_LOG2-1:0] win_val;
    logic [OUT_BITS-1:0] scaled;
    logic                win_end;
    logic                xfer;
    logic                load;

    assign win_end = (wcnt == WCNT_MAX);
    assign total   = acc + {{WIN_LOG2{1'b0}}, s2};
    // A window of all ones counts one past the largest representable value.
    assign sat     = total[WIN_LOG2] ? '1 : total[WIN_LOG2-1:0];

`ifdef PWM_DEC_CIC2_EN
    logic [WIN_LOG2-1:0] prev;
    logic [WIN_LOG2:0]   pair_sum;

    assign pair_sum = {1'b0, prev} + {1'b0, sat};
    assign win_val  = pair_sum[WIN_LOG2:1];

    // Tracks every window, even ones whose result is dropped on overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '0;
        end else if (win_end) begin
            prev <= sat;
        end
    end
`else
    assign win_val = sat;
`endif

    generate
        if (OUT_BITS <= WIN_LOG2) begin : g_trunc
            assign scaled = win_val[WIN_LOG2-1 -: OUT_BITS];
        end else begin : g_pad
            assign scaled = {win_val, {(OUT_BITS-WIN_LOG2){1'b0}}};
        end
    endgenerate

    assign xfer = sample_valid & sample_ready;
    assign load = win_end & (~sample_valid | xfer);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            wcnt         <= '0;
            acc          <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            s1   <= snd_in;
            s2   <= s1;
            wcnt <= wcnt + 1'b1;
            acc  <= win_end ? '0 : total;
            if (load) begin
                sample       <= scaled;
                sample_valid <= 1'b1;
            end else if (xfer) begin
                sample_valid <= 1'b0;
            end
            if (win_end && sample_valid && !xfer) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_snd_decoder.sv
// Directed bench for pwm_snd_decoder at default parameters; cycle 0 is the first cycle with reset low.
module tb_pwm_snd_decoder;

`ifdef PWM_DEC_CIC2_EN
    localparam int E_FIRST  = 126;
    localparam int E_SECOND = 252;
`else
    localparam int E_FIRST  = 252;
    localparam int E_SECOND = 254;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       snd_in = 1'b0;
    logic       sample_ready = 1'b0;
    logic [7:0] sample;
    logic       sample_valid;
    logic       overrun;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int mode      = 0;
    int pcnt      = 0;
    int cyc       = 0;

    always #5 clk = ~clk;

    pwm_snd_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .snd_in       (snd_in),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun)
    );

    // mode 0: low, 1: high, 2: toggle every clock, 3: high 3 of every 4 clocks
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pcnt++;
            cyc++;
            case (mode)
                1:       snd_in = 1'b1;
                2:       snd_in = pcnt[0];
                3:       snd_in = (pcnt[1:0] != 2'd0);
                default: snd_in = 1'b0;
            endcase
        end
    endtask

    task automatic tick_to(input int target);
        tick(target - cyc);
    endtask

    task automatic do_reset(input int m);
        reset = 1'b1;
        mode  = m;
        tick(3);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        tick(3);
        check("rst_sample", 32'(sample), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_overrun", 32'(overrun), 0);

        // Constant high, consumer always ready
        sample_ready = 1'b1;
        do_reset(1);
        tick_to(127); check("hi_c127_valid", 32'(sample_valid), 0);
        tick_to(128); check("hi_c128_valid", 32'(sample_valid), 1);
                      check("hi_c128_sample", 32'(sample), E_FIRST);
        tick_to(129); check("hi_c129_valid", 32'(sample_valid), 0);
        tick_to(256); check("hi_c256_valid", 32'(sample_valid), 1);
                      check("hi_c256_sample", 32'(sample), E_SECOND);
        tick_to(384); check("hi_c384_sample", 32'(sample), 254);
                      check("hi_overrun", 32'(overrun), 0);

        // Constant low
        do_reset(0);
        tick_to(128); check("lo_c128_valid", 32'(sample_valid), 1);
                      check("lo_c128_sample", 32'(sample), 0);
        tick_to(129); check("lo_c129_valid", 32'(sample_valid), 0);
        tick_to(255); check("lo_c255_valid", 32'(sample_valid), 0);
        tick_to(256); check("lo_c256_valid", 32'(sample_valid), 1);
                      check("lo_c256_sample", 32'(sample), 0);

        // 50% duty
        do_reset(2);
        tick_to(384); check("half_c384_sample", 32'(sample), 128);
        tick_to(512); check("half_c512_sample", 32'(sample), 128);

        // 75% duty
        do_reset(3);
        tick_to(384); check("q3_c384_sample", 32'(sample), 192);
        tick_to(512); check("q3_c512_sample", 32'(sample), 192);

        // Backpressure: not ready for 300 cycles with constant high
        sample_ready = 1'b0;
        do_reset(1);
        tick_to(128); check("bp_c128_valid", 32'(sample_valid), 1);
                      check("bp_c128_sample", 32'(sample), E_FIRST);
        tick_to(255); check("bp_c255_overrun", 32'(overrun), 0);
        tick_to(256); check("bp_c256_overrun", 32'(overrun), 1);
                      check("bp_c256_sample", 32'(sample), E_FIRST);
                      check("bp_c256_valid", 32'(sample_valid), 1);
        tick_to(300); sample_ready = 1'b1;
        tick_to(301); check("bp_c301_valid", 32'(sample_valid), 0);
        tick_to(383); check("bp_c383_valid", 32'(sample_valid), 0);
        tick_to(384); check("bp_c384_valid", 32'(sample_valid), 1);
                      check("bp_c384_sample", 32'(sample), 254);
                      check("bp_c384_overrun", 32'(overrun), 1);

        // Reset 60 cycles into the window starting at cycle 384
        tick_to(444);
        reset = 1'b1;
        tick(1);
        check("mid_rst_sample", 32'(sample), 0);
        check("mid_rst_valid", 32'(sample_valid), 0);
        check("mid_rst_overrun", 32'(overrun), 0);
        tick(1);
        reset = 1'b0;
        cyc   = 0;
        tick_to(127); check("mid_c127_valid", 32'(sample_valid), 0);
        tick_to(128); check("mid_c128_valid", 32'(sample_valid), 1);
                      check("mid_c128_sample", 32'(sample), E_FIRST);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pwm_snd_decoder.md
# pwm_snd_decoder

Receive-side companion to the square-wave PWM audio generator: takes a 1-bit PWM/pulse-density audio stream (such as the mixed `snd` output), synchronises it, and measures its duty cycle over fixed windows of 2^WIN_LOG2 clocks. Each window yields one multi-bit PCM sample, delivered on a valid/ready output port with overrun detection. It closes the loop in self-test and loopback benches and feeds downstream sample-rate logic.

## Interface
- `WIN_LOG2`, default 7: log2 of the window length in clocks; 128 clocks at 25.2 MHz gives 196.875 kHz.
- `OUT_BITS`, default 8: width of the output sample.
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `snd_in`  in  1: PWM audio input, asynchronous to `clk`.
- `sample`  out  OUT_BITS: decoded sample, unsigned; 0 = always low, full scale = always high.
- `sample_valid`  out  1: `sample` holds an undelivered value.
- `sample_ready`  in  1: consumer accepts `sample` this cycle.
- `overrun`  out  1: sticky; a window result was dropped because the previous one was not yet accepted.

## Operation
- **Synchroniser:** two flops `s1`, `s2`, both reset to 0. `s2` is the sampled bit.
- **Window counter** `wcnt`, WIN_LOG2 bits:
  - reset 0; increments every cycle and wraps at 2^WIN_LOG2−1.
  - `win_end` = (`wcnt` == 2^WIN_LOG2−1).
- **Accumulator** `acc`, WIN_LOG2+1 bits, reset 0:
  - `total` = `acc` + `s2`.
  - On `win_end`: `acc` ← 0 and `total` is latched as the window result.
  - Otherwise: `acc` ← `total`.
- **Saturation:** `total` lies in 0..2^WIN_LOG2. Saturate 2^WIN_LOG2 to 2^WIN_LOG2−1, giving `sat` of WIN_LOG2 bits.
- **Scaling:**
  - If OUT_BITS ≤ WIN_LOG2: `sample` gets the top OUT_BITS bits of `sat`.
  - Otherwise: `sat` shifted left by OUT_BITS−WIN_LOG2, zero-filled.
- **Output handshake:**
  - Transfer occurs when `sample_valid` && `sample_ready`.
  - On `win_end`, when `sample_valid` is 0 or a transfer occurs this cycle: load the new `sample` and set `sample_valid` to 1.
  - On `win_end` with `sample_valid` 1 and no transfer: discard the new result, keep the held `sample` unchanged, and set `overrun` to 1.
  - A transfer without `win_end` clears `sample_valid` next cycle.
  - `sample` stays stable while `sample_valid` is 1.
- **Reset values:** `sample` 0, `sample_valid` 0, `overrun` 0. `overrun` is cleared only by reset.
- **Reset mid-window:** discards the partial window and any held sample. The first window restarts at the cycle after reset deasserts.

## Timing
- Input-to-accumulate latency is 2 cycles (synchroniser).
- Cycle 0 is the first cycle with `reset` low; `wcnt` = 0 in that cycle.
- `win_end` falls in cycle 2^WIN_LOG2−1. `sample_valid` rises in cycle 2^WIN_LOG2, then every 2^WIN_LOG2 cycles.
- The first window after reset includes 2 zero bits from the synchroniser flush.
- `sample_ready` is combinationally unused toward `sample_valid`; there is no ready→valid combinational path.
- A consumer holding `sample_ready` high never causes an overrun.

## Configuration
- **`PWM_DEC_CIC2_EN` defined:** adds a second boxcar stage.
  - Register `prev`, WIN_LOG2 bits, reset 0, holds the previous `sat`.
  - The output value becomes (`prev` + `sat`) >> 1, WIN_LOG2 bits, truncated, then scaled as above.
  - `prev` ← `sat` on every `win_end`, including windows whose result is dropped.
  - Output latency is unchanged.
- **Undefined:** single-window boxcar, exactly as in Operation.

## Test plan
All scenarios use the defaults (WIN_LOG2=7, OUT_BITS=8) unless stated otherwise.

- **Constant high:** `snd_in` held at 1 from reset, `sample_ready`=1.
  - First sample 252 (126 ones, shifted left by 1) at cycle 128.
  - Every later sample 254 (128 ones, saturated to 127).
  - `overrun` stays 0.
- **Constant low:** `snd_in`=0 → every sample 0, one `sample_valid` pulse every 128 cycles.
- **50% duty:** `snd_in` toggles every clock.
  - Steady-state samples 128.
  - With `snd_in` high 3 of every 4 clocks: 192 (96 ones, shifted left by 1).
- **Backpressure:** `sample_ready`=0 for 300 cycles with constant high input.
  - `sample` holds 252 and `sample_valid` stays 1.
  - `overrun` goes to 1 at cycle 256.
  - After raising `sample_ready`, the next load occurs at the following `win_end`.
- **Reset mid-window:** assert `reset` at cycle 60 of a window, then release.
  - Outputs read 0/0/0 the next cycle.
  - The next `sample_valid` appears exactly 128 cycles after release.
- **With `PWM_DEC_CIC2_EN`, constant high:**
  - Samples are 126 ((0+126)>>1 = 63, shifted left by 1), then 252 ((126+127)>>1 = 126, shifted left by 1).
  - Then 254 in steady state.
